// File: rtl/rv32_pipe_pkg.sv
// Shared constants and types for the RV32I pipelined core.
// XLEN is common to fetch, hazard detection and forwarding.
package rv32_pipe_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StFetch,
        StWait,
        StDrop,
        StHold
    } fetch_state_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, instr} skid buffer for the fetch stage.
// Clear wins over push, push wins over pop.
module if_skid_buf #(
    parameter int unsigned Xlen = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  logic [Xlen-1:0] push_pc_i,
    input  logic [31:0]     push_instr_i,
    output logic            full_o,
    output logic [Xlen-1:0] pc_o,
    output logic [31:0]     instr_o
);

    logic            full_q, full_d;
    logic [Xlen-1:0] pc_q, pc_d;
    logic [31:0]     instr_q, instr_d;

    always_comb begin
        full_d  = full_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (clear_i) begin
            full_d = 1'b0;
        end else if (push_i) begin
            full_d  = 1'b1;
            pc_d    = push_pc_i;
            instr_d = push_instr_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            full_q  <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            full_q  <= full_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage and IF/ID register: single-outstanding imem port, stall/flush handling,
// and a one-entry skid for a response that lands while decode is stalled.
module if_fetch_stage
    import rv32_pipe_pkg::*;
#(
    parameter int unsigned     Xlen     = XLEN,
    parameter logic [Xlen-1:0] ResetPc  = RESET_PC,
    parameter logic [31:0]     NopInstr = NOP_INSTR
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            stall,
    input  logic            flush,
    input  logic [Xlen-1:0] redirect_pc,
    output logic            imem_req,
    output logic [Xlen-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [Xlen-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid
);

    fetch_state_t    state_q, state_d;
    logic [Xlen-1:0] pc_q, pc_d;
    logic [Xlen-1:0] inflight_pc_q, inflight_pc_d;
    logic [Xlen-1:0] if_id_pc_q, if_id_pc_d;
    logic [31:0]     if_id_instr_q, if_id_instr_d;
    logic            if_id_valid_q, if_id_valid_d;

    logic            skid_push, skid_pop, skid_clear, skid_full;
    logic [Xlen-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            resp_live;

    // Redirect targets are word-aligned; the low bits are intentionally dropped.
    logic unused_redirect_lsb;
    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // A response only counts while a live request is outstanding.
    assign resp_live = (state_q == StWait) && imem_rvalid;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        skid_push     = 1'b0;
        skid_pop      = 1'b0;
        skid_clear    = 1'b0;

        unique case (state_q)
            StFetch: begin
                if (imem_gnt) begin
                    state_d       = StWait;
                    inflight_pc_d = pc_q;
                    pc_d          = pc_q + Xlen'(4);
                end
            end
            StWait: begin
                if (imem_rvalid) begin
                    state_d = stall ? StHold : StFetch;
                end
            end
            StDrop: begin
                if (imem_rvalid) begin
                    state_d = StFetch;
                end
            end
            StHold: begin
                if (!stall) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase

        if (flush) begin
            skid_clear    = 1'b1;
            if_id_valid_d = 1'b0;
            if_id_instr_d = NopInstr;
            pc_d          = {redirect_pc[Xlen-1:2], 2'b00};
            case (state_q)
                StFetch: state_d = imem_gnt ? StDrop : StFetch;
                StWait:  state_d = imem_rvalid ? StFetch : StDrop;
                StHold:  state_d = StFetch;
                default: ;
            endcase
        end else if (stall) begin
            skid_push = resp_live;
        end else if (skid_full) begin
            skid_pop      = 1'b1;
            if_id_valid_d = 1'b1;
            if_id_pc_d    = skid_pc;
            if_id_instr_d = skid_instr;
        end else if (resp_live) begin
            if_id_valid_d = 1'b1;
            if_id_pc_d    = inflight_pc_q;
            if_id_instr_d = imem_rdata;
        end else begin
            if_id_valid_d = 1'b0;
            if_id_instr_d = NopInstr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= StFetch;
            pc_q          <= ResetPc;
            inflight_pc_q <= '0;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NopInstr;
            if_id_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    if_skid_buf #(
        .Xlen(Xlen)
    ) u_skid (
        .clk         (clk),
        .rstn        (rstn),
        .push_i      (skid_push),
        .pop_i       (skid_pop),
        .clear_i     (skid_clear),
        .push_pc_i   (inflight_pc_q),
        .push_instr_i(imem_rdata),
        .full_o      (skid_full),
        .pc_o        (skid_pc),
        .instr_o     (skid_instr)
    );

    assign imem_req    = rstn && (state_q == StFetch);
    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;

endmodule
